// File: rtl/mem_initiator_d1.sv
// Requester side of a single-port block RAM with 1-cycle read latency.
// Credit-limited reads, in-order responses through a small circular FIFO.
module mem_initiator_d1 #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int RESP_DEPTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [DATA_W-1:0] req_writedata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int OW = $clog2(RESP_DEPTH + 1);
  localparam int CW = $clog2(RESP_DEPTH + 2);

  logic              inflight_q, inflight_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic [DATA_W-1:0] buf_q [RESP_DEPTH];

  logic          fire;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits come from registered state only, so resp_ready never reaches req_ready.
  assign count     = CW'(occ_q) + CW'(inflight_q);
  assign req_ready = ~reset & (count < CW'(RESP_DEPTH));
  assign fire      = req_valid & req_ready;

  assign mem_address   = req_address;
  assign mem_writedata = req_writedata;
  assign mem_write     = fire & req_write;
  assign mem_read      = fire & ~req_write;

  assign resp_valid    = ~reset & (occ_q != '0);
  assign resp_readdata = resp_valid ? buf_q[rd_q] : '0;

  assign push = inflight_q;
  assign pop  = resp_valid & resp_ready;

  always_comb begin
    inflight_d = fire & ~req_write;
    wr_d       = push ? nxt(wr_q) : wr_q;
    rd_d       = pop ? nxt(rd_q) : rd_q;
    occ_d      = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      occ_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      occ_q      <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      buf_q[wr_q] <= mem_readdata;
    end
  end

  push_full_a: assert property (
    @(posedge clk) disable iff (reset)
    !(push && occ_q == OW'(RESP_DEPTH))
  );

endmodule

// File: tb/tb_mem_initiator_d1.sv
// Directed and randomized checks of mem_initiator_d1 against a 1-cycle RAM
// and a reference memory array.
module tb_mem_initiator_d1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [11:0] req_address;
  logic [15:0] req_writedata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_readdata;
  logic [11:0] mem_address;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_writedata;
  logic [15:0] mem_readdata;

  logic [15:0] ram     [4096];
  logic [15:0] ref_mem [4096];
  logic [15:0] exp_q [$];
  logic [15:0] rx_q [$];

  int   total = 0;
  int   bad = 0;
  int   n_resp = 0;
  logic last_rv;
  logic last_rdy;

  always #5 clk = ~clk;

  mem_initiator_d1 dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_address  (req_address),
    .req_writedata(req_writedata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_readdata(resp_readdata),
    .mem_address  (mem_address),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata)
  );

  always @(posedge clk) begin
    if (mem_write) ram[mem_address] <= mem_writedata;
    if (mem_read) mem_readdata <= ram[mem_address];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_resp", 32'd1, 32'd0);
      end else begin
        chk("rdata", {16'd0, resp_readdata}, {16'd0, exp_q.pop_front()});
        rx_q.push_back(resp_readdata);
        n_resp++;
      end
    end
  end

  task automatic drive(input logic v, input logic w, input logic [11:0] a,
                       input logic [15:0] d, output logic f);
    req_valid     = v;
    req_write     = w;
    req_address   = a;
    req_writedata = d;
    @(negedge clk);
    last_rv  = resp_valid;
    last_rdy = req_ready;
    f = v & req_ready;
    if (f) begin
      chk("mem_wr", {31'd0, mem_write}, {31'd0, w});
      chk("mem_rd", {31'd0, mem_read}, {31'd0, ~w});
      chk("mem_addr", {20'd0, mem_address}, {20'd0, a});
      if (w) begin
        chk("mem_wdata", {16'd0, mem_writedata}, {16'd0, d});
        ref_mem[a] = d;
      end else begin
        exp_q.push_back(ref_mem[a]);
      end
    end else begin
      chk("mem_idle", {30'd0, mem_read, mem_write}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic f;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 12'h0, 16'h0, f);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic f;
    int   n0;
    int   acc;
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = 16'hC000 | 16'(i);
      ref_mem[i] = 16'hC000 | 16'(i);
    end
    reset         = 1'b1;
    req_valid     = 1'b1;
    req_write     = 1'b0;
    req_address   = 12'h0;
    req_writedata = 16'h0;
    resp_ready    = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rdy", {31'd0, req_ready}, 32'd0);
    chk("rst_rv", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", {16'd0, resp_readdata}, 32'd0);
    chk("rst_mem", {30'd0, mem_read, mem_write}, 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", {31'd0, req_ready}, 32'd1);
    chk("post_rst_rv", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;

    // 1: write then read back with latency check
    resp_ready = 1'b1;
    drive(1'b1, 1'b1, 12'h123, 16'hBEEF, f);
    chk("t1_wfire", {31'd0, f}, 32'd1);
    n0 = n_resp;
    rx_q.delete();
    drive(1'b1, 1'b0, 12'h123, 16'h0, f);
    chk("t1_rfire", {31'd0, f}, 32'd1);
    drive(1'b0, 1'b0, 12'h0, 16'h0, f);
    chk("t1_lat1", {31'd0, last_rv}, 32'd0);
    drive(1'b0, 1'b0, 12'h0, 16'h0, f);
    chk("t1_lat2", {31'd0, last_rv}, 32'd1);
    drive(1'b0, 1'b0, 12'h0, 16'h0, f);
    chk("t1_once", {31'd0, last_rv}, 32'd0);
    chk("t1_cnt", n_resp - n0, 32'd1);
    if (rx_q.size() > 0) chk("t1_data", {16'd0, rx_q[0]}, 32'h0000BEEF);

    // 2: streaming reads, one response per cycle
    n0 = n_resp;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) drive(1'b1, 1'b0, 12'(i), 16'h0, f);
      else drive(1'b0, 1'b0, 12'h0, 16'h0, f);
      if (i < 16) chk("t2_rdy", {31'd0, last_rdy}, 32'd1);
      if (i >= 2) chk("t2_rv", {31'd0, last_rv}, 32'd1);
    end
    idle(1);
    chk("t2_cnt", n_resp - n0, 32'd16);

    // 3: back-pressure fills all credits
    resp_ready = 1'b0;
    n0 = n_resp;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 12'h020 + 12'(acc), 16'h0, f);
      if (f) acc++;
    end
    chk("t3_acc", acc, 32'd3);
    chk("t3_full", {31'd0, last_rdy}, 32'd0);
    resp_ready = 1'b1;
    idle(4);
    chk("t3_cnt", n_resp - n0, 32'd3);
    chk("t3_rdy", {31'd0, last_rdy}, 32'd1);

    // 4: alternating write/read at top address
    n0 = n_resp;
    rx_q.delete();
    drive(1'b1, 1'b1, 12'hFFF, 16'h0001, f);
    drive(1'b1, 1'b0, 12'hFFF, 16'h0, f);
    drive(1'b1, 1'b1, 12'hFFF, 16'h0002, f);
    drive(1'b1, 1'b0, 12'hFFF, 16'h0, f);
    idle(3);
    chk("t4_cnt", n_resp - n0, 32'd2);
    if (rx_q.size() >= 2) begin
      chk("t4_d0", {16'd0, rx_q[0]}, 32'h00000001);
      chk("t4_d1", {16'd0, rx_q[1]}, 32'h00000002);
    end

    // 5: reset while a read is in flight
    drive(1'b1, 1'b0, 12'h040, 16'h0, f);
    chk("t5_fire", {31'd0, f}, 32'd1);
    reset     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    @(negedge clk);
    chk("t5_rdy", {31'd0, req_ready}, 32'd0);
    chk("t5_rv", {31'd0, resp_valid}, 32'd0);
    chk("t5_rdata", {16'd0, resp_readdata}, 32'd0);
    chk("t5_mem", {30'd0, mem_read, mem_write}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    n0 = n_resp;
    idle(4);
    chk("t5_none", n_resp - n0, 32'd0);
    chk("t5_rv_after", {31'd0, last_rv}, 32'd0);
    rx_q.delete();
    drive(1'b1, 1'b0, 12'h010, 16'h0, f);
    idle(3);
    chk("t5_cnt", n_resp - n0, 32'd1);
    if (rx_q.size() > 0) chk("t5_data", {16'd0, rx_q[0]}, 32'h0000C010);

    // 6: randomized traffic against the reference memory
    for (int i = 0; i < 3000; i++) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            12'h100 + 12'($urandom_range(0, 7)), 16'($urandom), f);
    end
    resp_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("t6_drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
